// File: rtl/key_sched_256_seq.sv
`default_nettype none
// ============================================================================
//  Module   : key_sched_256_seq
//  Purpose  : Iterative AES-256 key-schedule controller. Captures a 256-bit
//             cipher key and runs seven evolve_key_256 steps, one per clock.
//             It keeps the 15 resulting 128-bit round keys in a local buffer
//             that the round datapath reads by index.
//  Ports    : clk         - system clock, rising edge
//             n_rst       - asynchronous active-low reset
//             zeroize     - (KEY_SCHED_ZEROIZE_EN only) wipe all key material
//             start       - one-cycle request to expand key_in
//             key_in      - cipher key, w0 = key_in[255:224] .. w7 = [31:0]
//             busy        - expansion in progress
//             done        - one-cycle pulse when expansion completes
//             keys_ready  - level, all round keys valid
//             rk_rd_en    - round-key read strobe
//             rk_rd_idx   - round-key index 0..14
//             rk_out      - registered round key {w4i, .., w4i+3}
//             rk_valid    - rk_out holds a valid read result
//  Options  : define KEY_SCHED_ZEROIZE_EN to add the zeroize input
//  Revision : 1.0 - initial release
// ============================================================================
module key_sched_256_seq #(
    parameter int NUM_RK = 15
) (
    input  logic         clk,
    input  logic         n_rst,
`ifdef KEY_SCHED_ZEROIZE_EN
    input  logic         zeroize,
`endif
    input  logic         start,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         keys_ready,
    input  logic         rk_rd_en,
    input  logic [3:0]   rk_rd_idx,
    output logic [127:0] rk_out,
    output logic         rk_valid
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXPAND = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [3:0] C_LAST_IDX  = 4'(NUM_RK - 1);
    localparam logic [2:0] C_LAST_STEP = 3'd6;

    // Forward S-box, byte 0x00 in the top bits.
    localparam logic [2047:0] C_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] pos;
        // (255 - b) * 8, since the table is stored MSB-first
        pos = {~b, 3'b000};
        return C_SBOX[pos +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // One AES-256 schedule step: eight old words -> eight new words.
    function automatic logic [255:0] evolve_key_256(input logic [255:0] k,
                                                    input logic [7:0]   rc);
        logic [31:0] n0, n1, n2, n3, n4, n5, n6, n7;
        n0 = k[255:224] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
        n1 = k[223:192] ^ n0;
        n2 = k[191:160] ^ n1;
        n3 = k[159:128] ^ n2;
        n4 = k[127:96]  ^ sub_word(n3);
        n5 = k[95:64]   ^ n4;
        n6 = k[63:32]   ^ n5;
        n7 = k[31:0]    ^ n6;
        return {n0, n1, n2, n3, n4, n5, n6, n7};
    endfunction

    logic [1:0]   r_state;
    logic [2:0]   r_cnt;
    logic [7:0]   r_rcon;
    logic [255:0] r_key;
    logic [127:0] r_rk [NUM_RK];
    logic         r_busy;
    logic         r_done;
    logic         r_keys_ready;
    logic [127:0] r_rk_out;
    logic         r_rk_valid;

    logic [255:0] w_next_key;
    logic [7:0]   w_next_rcon;
    logic [3:0]   w_idx_hi;
    logic [3:0]   w_idx_lo;
    logic         w_last_step;
    logic         w_start_go;

    assign w_next_key  = evolve_key_256(r_key, r_rcon);
    assign w_next_rcon = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
    assign w_idx_hi    = {r_cnt, 1'b0} + 4'd2;
    assign w_idx_lo    = {r_cnt, 1'b0} + 4'd3;
    assign w_last_step = (r_cnt == C_LAST_STEP);
    // A start is only honoured outside EXPAND; a read on that same edge is
    // refused because the buffer is about to be rewritten.
    assign w_start_go  = start && (r_state != S_EXPAND);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 3'd0;
            r_rcon       <= 8'h01;
            r_key        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_keys_ready <= 1'b0;
            r_rk_out     <= '0;
            r_rk_valid   <= 1'b0;
            for (int i = 0; i < NUM_RK; i++) r_rk[i] <= '0;
        end else begin
            r_done <= 1'b0;
`ifdef KEY_SCHED_ZEROIZE_EN
            if (zeroize) begin
                r_state      <= S_IDLE;
                r_cnt        <= 3'd0;
                r_rcon       <= 8'h01;
                r_key        <= '0;
                r_busy       <= 1'b0;
                r_keys_ready <= 1'b0;
                r_rk_out     <= '0;
                r_rk_valid   <= 1'b0;
                for (int i = 0; i < NUM_RK; i++) r_rk[i] <= '0;
            end else
`endif
            begin
                if (rk_rd_en) begin
                    if (r_keys_ready && !w_start_go && (rk_rd_idx <= C_LAST_IDX)) begin
                        r_rk_out   <= r_rk[rk_rd_idx];
                        r_rk_valid <= 1'b1;
                    end else begin
                        r_rk_out   <= '0;
                        r_rk_valid <= 1'b0;
                    end
                end else begin
                    r_rk_valid <= 1'b0;
                end

                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            r_key        <= key_in;
                            r_rk[0]      <= key_in[255:128];
                            r_rk[1]      <= key_in[127:0];
                            r_rcon       <= 8'h01;
                            r_cnt        <= 3'd0;
                            r_keys_ready <= 1'b0;
                            r_busy       <= 1'b1;
                            r_state      <= S_EXPAND;
                        end
                    end
                    S_EXPAND: begin
                        r_key          <= w_next_key;
                        r_rcon         <= w_next_rcon;
                        r_rk[w_idx_hi] <= w_next_key[255:128];
                        if (w_last_step) begin
                            // Last step only produces rk[14]; the low half
                            // of the final evolved key is not a round key.
                            r_cnt        <= 3'd0;
                            r_state      <= S_DONE;
                            r_busy       <= 1'b0;
                            r_keys_ready <= 1'b1;
                            r_done       <= 1'b1;
                        end else begin
                            r_rk[w_idx_lo] <= w_next_key[127:0];
                            r_cnt          <= r_cnt + 3'd1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign keys_ready = r_keys_ready;
    assign rk_out     = r_rk_out;
    assign rk_valid   = r_rk_valid;

endmodule
`default_nettype wire

// File: tb/tb_key_sched_256_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_sched_256_seq
//  Purpose  : Directed self-checking bench for key_sched_256_seq using the
//             FIPS-197 AES-256 key and the all-zero key as reference vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_key_sched_256_seq;

    localparam logic [255:0] K1 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] K2 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] K1_RK0  = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] K1_RK1  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] K1_RK2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] K1_RK3  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
    localparam logic [127:0] K1_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [127:0] KZ_RK2  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] KZ_RK3  = 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb;
    localparam logic [127:0] K2_RK0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2_RK1  = 128'h101112131415161718191a1b1c1d1e1f;

    logic         clk;
    logic         n_rst;
    logic         start;
    logic [255:0] key_in;
    logic         busy;
    logic         done;
    logic         keys_ready;
    logic         rk_rd_en;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_out;
    logic         rk_valid;
`ifdef KEY_SCHED_ZEROIZE_EN
    logic         zeroize;
`endif

    int errors = 0;
    int checks = 0;

    key_sched_256_seq dut (
        .clk        (clk),
        .n_rst      (n_rst),
`ifdef KEY_SCHED_ZEROIZE_EN
        .zeroize    (zeroize),
`endif
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .keys_ready (keys_ready),
        .rk_rd_en   (rk_rd_en),
        .rk_rd_idx  (rk_rd_idx),
        .rk_out     (rk_out),
        .rk_valid   (rk_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [3:0] idx);
        rk_rd_en  = 1'b1;
        rk_rd_idx = idx;
        tick();
        rk_rd_en  = 1'b0;
    endtask

    // Launch an expansion and wait (bounded) for the done pulse.
    task automatic run_expand(input logic [255:0] key, input string name);
        bit seen;
        seen   = 1'b0;
        start  = 1'b1;
        key_in = key;
        tick();
        start  = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done_timeout: done=0 required done=1 within 12 cycles", name);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b1;
        #2;
        n_rst = 1'b0;
        tick();
        checks++;
        if ({busy, done, keys_ready, rk_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0000", {busy, done, keys_ready, rk_valid});
        end
        checks++;
        if (rk_out !== 128'h0) begin
            errors++;
            $display("FAIL reset_rk_out: got %h required 0", rk_out);
        end
        @(negedge clk);
        n_rst = 1'b1;
        tick();
    endtask

    task automatic test_expand();
        int busy_cnt;
        bit done_early;
        start  = 1'b1;
        key_in = K1;
        tick();
        start  = 1'b0;
        key_in = '1;
        busy_cnt   = busy ? 1 : 0;
        done_early = done;
        checks++;
        if (keys_ready !== 1'b0) begin
            errors++;
            $display("FAIL expand_keys_ready_low: got %b required 0", keys_ready);
        end
        for (int i = 1; i < 7; i++) begin
            if (i == 3) begin
                rk_rd_en  = 1'b1;
                rk_rd_idx = 4'd0;
            end
            tick();
            rk_rd_en = 1'b0;
            if (busy) busy_cnt++;
            if (done) done_early = 1'b1;
            if (i == 3) begin
                checks++;
                if (rk_valid !== 1'b0 || rk_out !== 128'h0) begin
                    errors++;
                    $display("FAIL read_while_busy: valid=%b out=%h required valid=0 out=0", rk_valid, rk_out);
                end
            end
        end
        tick();
        checks++;
        if (busy_cnt != 7 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_length: got %0d cycles (busy now %b) required 7 cycles then 0", busy_cnt, busy);
        end
        checks++;
        if (done !== 1'b1 || done_early) begin
            errors++;
            $display("FAIL done_timing: done=%b early=%b required done=1 early=0", done, done_early);
        end
        checks++;
        if (keys_ready !== 1'b1) begin
            errors++;
            $display("FAIL keys_ready_set: got %b required 1", keys_ready);
        end
        tick();
        checks++;
        if (done !== 1'b0 || keys_ready !== 1'b1) begin
            errors++;
            $display("FAIL done_single_pulse: done=%b keys_ready=%b required 0/1", done, keys_ready);
        end
    endtask

    task automatic test_read_keys();
        logic [3:0]   idx [5]  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd14};
        logic [127:0] expv [5] = '{K1_RK0, K1_RK1, K1_RK2, K1_RK3, K1_RK14};
        for (int i = 0; i < 5; i++) begin
            do_read(idx[i]);
            checks++;
            if (rk_valid !== 1'b1 || rk_out !== expv[i]) begin
                errors++;
                $display("FAIL read_rk%0d: valid=%b out=%h required valid=1 out=%h", idx[i], rk_valid, rk_out, expv[i]);
            end
        end
    endtask

    task automatic test_read_boundaries();
        do_read(4'd14);
        tick();
        checks++;
        if (rk_valid !== 1'b0 || rk_out !== K1_RK14) begin
            errors++;
            $display("FAIL read_en_low_hold: valid=%b out=%h required valid=0 out=%h", rk_valid, rk_out, K1_RK14);
        end
        do_read(4'd15);
        checks++;
        if (rk_valid !== 1'b0 || rk_out !== 128'h0) begin
            errors++;
            $display("FAIL read_idx15: valid=%b out=%h required valid=0 out=0", rk_valid, rk_out);
        end
    endtask

    task automatic test_start_while_busy();
        bit done_early;
        done_early = 1'b0;
        start  = 1'b1;
        key_in = K1;
        tick();
        start  = 1'b0;
        tick();
        tick();
        start  = 1'b1;
        key_in = K2;
        tick();
        start  = 1'b0;
        for (int i = 4; i < 7; i++) begin
            tick();
            if (done) done_early = 1'b1;
        end
        tick();
        checks++;
        if (done !== 1'b1 || done_early) begin
            errors++;
            $display("FAIL collide_done_time: done=%b early=%b required done=1 early=0", done, done_early);
        end
        tick();
        do_read(4'd2);
        checks++;
        if (rk_valid !== 1'b1 || rk_out !== K1_RK2) begin
            errors++;
            $display("FAIL collide_rk2: valid=%b out=%h required valid=1 out=%h", rk_valid, rk_out, K1_RK2);
        end
        do_read(4'd14);
        checks++;
        if (rk_valid !== 1'b1 || rk_out !== K1_RK14) begin
            errors++;
            $display("FAIL collide_rk14: valid=%b out=%h required valid=1 out=%h", rk_valid, rk_out, K1_RK14);
        end
    endtask

    task automatic test_start_in_done();
        bit seen;
        seen      = 1'b0;
        start     = 1'b1;
        key_in    = '0;
        rk_rd_en  = 1'b1;
        rk_rd_idx = 4'd0;
        tick();
        start    = 1'b0;
        rk_rd_en = 1'b0;
        checks++;
        if (keys_ready !== 1'b0 || rk_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_in_done: keys_ready=%b valid=%b busy=%b required 0/0/1", keys_ready, rk_valid, busy);
        end
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL restart_done_timeout: done=0 required done=1 within 12 cycles");
        end
        do_read(4'd0);
        checks++;
        if (rk_valid !== 1'b1 || rk_out !== 128'h0) begin
            errors++;
            $display("FAIL zero_key_rk0: valid=%b out=%h required valid=1 out=0", rk_valid, rk_out);
        end
        do_read(4'd3);
        checks++;
        if (rk_out !== KZ_RK3) begin
            errors++;
            $display("FAIL zero_key_rk3: got %h required %h", rk_out, KZ_RK3);
        end
        do_read(4'd2);
        checks++;
        if (rk_valid !== 1'b1 || rk_out !== KZ_RK2) begin
            errors++;
            $display("FAIL zero_key_rk2: valid=%b out=%h required valid=1 out=%h", rk_valid, rk_out, KZ_RK2);
        end
    endtask

    task automatic test_reset_mid_expand();
        bit seen;
        seen   = 1'b0;
        start  = 1'b1;
        key_in = K1;
        tick();
        start  = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, keys_ready, rk_valid} !== 4'b0000 || rk_out !== 128'h0) begin
            errors++;
            $display("FAIL async_reset: flags=%b out=%h required 0000 / 0", {busy, done, keys_ready, rk_valid}, rk_out);
        end
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        checks++;
        if (seen || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: done_seen=%b busy=%b required 0/0", seen, busy);
        end
        do_read(4'd0);
        checks++;
        if (rk_valid !== 1'b0 || rk_out !== 128'h0) begin
            errors++;
            $display("FAIL read_after_reset: valid=%b out=%h required valid=0 out=0", rk_valid, rk_out);
        end
        run_expand(K2, "fresh");
        tick();
        do_read(4'd0);
        checks++;
        if (rk_valid !== 1'b1 || rk_out !== K2_RK0) begin
            errors++;
            $display("FAIL fresh_rk0: valid=%b out=%h required valid=1 out=%h", rk_valid, rk_out, K2_RK0);
        end
        do_read(4'd1);
        checks++;
        if (rk_out !== K2_RK1) begin
            errors++;
            $display("FAIL fresh_rk1: got %h required %h", rk_out, K2_RK1);
        end
    endtask

`ifdef KEY_SCHED_ZEROIZE_EN
    task automatic test_zeroize();
        bit seen;
        seen   = 1'b0;
        start  = 1'b1;
        key_in = K1;
        tick();
        start  = 1'b0;
        tick();
        tick();
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        checks++;
        if ({busy, keys_ready, rk_valid} !== 3'b000 || rk_out !== 128'h0) begin
            errors++;
            $display("FAIL zeroize_mid: flags=%b out=%h required 000 / 0", {busy, keys_ready, rk_valid}, rk_out);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL zeroize_no_done: done_seen=1 required 0");
        end
        do_read(4'd0);
        checks++;
        if (rk_valid !== 1'b0 || rk_out !== 128'h0) begin
            errors++;
            $display("FAIL zeroize_read: valid=%b out=%h required valid=0 out=0", rk_valid, rk_out);
        end
    endtask

    task automatic test_zeroize_start();
        zeroize = 1'b1;
        start   = 1'b1;
        key_in  = K1;
        tick();
        zeroize = 1'b0;
        start   = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL zeroize_beats_start: busy=%b done=%b required 0/0", busy, done);
        end
        run_expand(K1, "pre_zeroize");
        tick();
        zeroize   = 1'b1;
        rk_rd_en  = 1'b1;
        rk_rd_idx = 4'd0;
        tick();
        zeroize  = 1'b0;
        rk_rd_en = 1'b0;
        checks++;
        if ({keys_ready, rk_valid} !== 2'b00 || rk_out !== 128'h0) begin
            errors++;
            $display("FAIL zeroize_beats_read: flags=%b out=%h required 00 / 0", {keys_ready, rk_valid}, rk_out);
        end
    endtask
`endif

    initial begin
        n_rst     = 1'b1;
        start     = 1'b0;
        key_in    = '0;
        rk_rd_en  = 1'b0;
        rk_rd_idx = 4'd0;
`ifdef KEY_SCHED_ZEROIZE_EN
        zeroize   = 1'b0;
`endif
        test_reset();
        test_expand();
        test_read_keys();
        test_read_boundaries();
        test_start_while_busy();
        test_start_in_done();
        test_reset_mid_expand();
`ifdef KEY_SCHED_ZEROIZE_EN
        test_zeroize();
        test_zeroize_start();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
